// File: rtl/exc_pkg.sv
// Shared constants for the exception commit stage: raw flag bit indices,
// control-word field positions, FSM state encoding and the default vector.
package exc_pkg;

  localparam int EXC_ADEL_IF  = 0;
  localparam int EXC_RI       = 1;
  localparam int EXC_OV       = 2;
  localparam int EXC_BREAK    = 3;
  localparam int EXC_SYSCALL  = 4;
  localparam int EXC_ADEL_MA  = 5;
  localparam int EXC_ERET     = 6;
  localparam int EXC_ADES     = 7;

  localparam int WORD_VLD_BIT  = 15;
  localparam int WORD_DLY_BIT  = 8;
  localparam int WORD_CODE_MSB = 7;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam logic [7:0]  CODE_ERET          = 8'h40;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  function automatic logic [15:0] make_word(input logic dly, input logic [7:0] code);
    logic [15:0] w;
    w                         = '0;
    w[WORD_VLD_BIT]           = 1'b1;
    w[WORD_DLY_BIT]           = dly;
    w[WORD_CODE_MSB:0]        = code;
    return w;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational 8-bit raw-flag to one-hot encoder; zero latency, no handshake.
// Priority highest first: AdEL-IF, RI, Ov, Break, Syscall, AdEL-MA, AdES, ERET.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [7:0] raw,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (raw[EXC_ADEL_IF])      onehot[EXC_ADEL_IF] = 1'b1;
    else if (raw[EXC_RI])      onehot[EXC_RI]      = 1'b1;
    else if (raw[EXC_OV])      onehot[EXC_OV]      = 1'b1;
    else if (raw[EXC_BREAK])   onehot[EXC_BREAK]   = 1'b1;
    else if (raw[EXC_SYSCALL]) onehot[EXC_SYSCALL] = 1'b1;
    else if (raw[EXC_ADEL_MA]) onehot[EXC_ADEL_MA] = 1'b1;
    else if (raw[EXC_ADES])    onehot[EXC_ADES]    = 1'b1;
    else if (raw[EXC_ERET])    onehot[EXC_ERET]    = 1'b1;
  end

endmodule

// File: rtl/exc_commit_unit.sv
// Dual-lane exception commit: registered CP0 words 1 cycle after capture, then flush and a
// redirect held until redirect_ready. Optional counters under EXC_COMMIT_STATS_EN.
module exc_commit_unit
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_1,
  input  logic        valid_2,
  input  logic [7:0]  exc_raw_1,
  input  logic [7:0]  exc_raw_2,
  input  logic        is_delay_1,
  input  logic        is_delay_2,
  input  logic [31:0] pc_1,
  input  logic [31:0] pc_2,
  input  logic [31:0] vaddr_1,
  input  logic [31:0] vaddr_2,
  input  logic [31:0] epc_i,
  output logic [15:0] int_contr_word_1,
  output logic [15:0] int_contr_word_2,
  output logic [31:0] pc_o_1,
  output logic [31:0] pc_o_2,
  output logic [31:0] vaddr_o_1,
  output logic [31:0] vaddr_o_2,
  output logic        kill_2,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
`ifdef EXC_COMMIT_STATS_EN
  ,
  output logic [31:0] exc_count,
  output logic [15:0] eret_count
`endif
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  logic [7:0] onehot_1, onehot_2;
  logic       exc_1, exc_2;

  exc_prio_enc u_enc_1 (.raw(exc_raw_1), .onehot(onehot_1));
  exc_prio_enc u_enc_2 (.raw(exc_raw_2), .onehot(onehot_2));

  assign exc_1 = valid_1 && (exc_raw_1 != 8'h00);
  assign exc_2 = valid_2 && (exc_raw_2 != 8'h00);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  code_q, code_d;
  logic [15:0] word_1_q, word_1_d, word_2_q, word_2_d;
  logic [31:0] pc_o_1_q, pc_o_1_d, pc_o_2_q, pc_o_2_d;
  logic [31:0] vaddr_o_1_q, vaddr_o_1_d, vaddr_o_2_q, vaddr_o_2_d;
  logic        kill_2_q, kill_2_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        commit_start;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    code_d           = code_q;
    word_1_d         = '0;
    word_2_d         = '0;
    pc_o_1_d         = '0;
    pc_o_2_d         = '0;
    vaddr_o_1_d      = '0;
    vaddr_o_2_d      = '0;
    kill_2_d         = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    commit_start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_1 || exc_2) begin
          commit_start = 1'b1;
          state_d      = COMMIT;
          // Lane 1 is older, so it always wins and lane 2 gets squashed.
          if (exc_1) begin
            code_d      = onehot_1;
            word_1_d    = make_word(is_delay_1, onehot_1);
            pc_o_1_d    = pc_1;
            vaddr_o_1_d = vaddr_1;
            kill_2_d    = valid_2;
          end else begin
            code_d      = onehot_2;
            word_2_d    = make_word(is_delay_2, onehot_2);
            pc_o_2_d    = pc_2;
            vaddr_o_2_d = vaddr_2;
          end
        end
      end
      COMMIT: begin
        state_d = FLUSH;
        cnt_d   = FLUSH_INIT;
        flush_d = 1'b1;
      end
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d          = REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = (code_q == CODE_ERET) ? epc_i : EXC_VECTOR;
        end else begin
          flush_d = 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d       = IDLE;
          redirect_pc_d = '0;
        end else begin
          redirect_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      code_q           <= '0;
      word_1_q         <= '0;
      word_2_q         <= '0;
      pc_o_1_q         <= '0;
      pc_o_2_q         <= '0;
      vaddr_o_1_q      <= '0;
      vaddr_o_2_q      <= '0;
      kill_2_q         <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      code_q           <= code_d;
      word_1_q         <= word_1_d;
      word_2_q         <= word_2_d;
      pc_o_1_q         <= pc_o_1_d;
      pc_o_2_q         <= pc_o_2_d;
      vaddr_o_1_q      <= vaddr_o_1_d;
      vaddr_o_2_q      <= vaddr_o_2_d;
      kill_2_q         <= kill_2_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign int_contr_word_1 = word_1_q;
  assign int_contr_word_2 = word_2_q;
  assign pc_o_1           = pc_o_1_q;
  assign pc_o_2           = pc_o_2_q;
  assign vaddr_o_1        = vaddr_o_1_q;
  assign vaddr_o_2        = vaddr_o_2_q;
  assign kill_2           = kill_2_q;
  assign flush            = flush_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;

`ifdef EXC_COMMIT_STATS_EN
  logic [31:0] exc_count_q, exc_count_d;
  logic [15:0] eret_count_q, eret_count_d;

  always_comb begin
    exc_count_d  = exc_count_q;
    eret_count_d = eret_count_q;
    if (commit_start) begin
      exc_count_d = exc_count_q + 32'd1;
      if ((code_d == CODE_ERET) && (eret_count_q != 16'hFFFF)) begin
        eret_count_d = eret_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_count_q  <= '0;
      eret_count_q <= '0;
    end else begin
      exc_count_q  <= exc_count_d;
      eret_count_q <= eret_count_d;
    end
  end

  assign exc_count  = exc_count_q;
  assign eret_count = eret_count_q;
`endif

endmodule

// File: doc/exc_commit_unit.md
# exc_commit_unit

Dual-lane exception commit stage between the MEM pipeline registers and the CP0 block. Each cycle it collects per-lane raw exception flags, picks the single oldest exception by lane order and in-lane priority, and presents CP0 with one-cycle control words (`int_contr_word_1/2`), PCs and bad addresses. It then runs the flush/redirect sequence that kills younger work and steers fetch to the exception vector, or to EPC on ERET.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every non-ERET exception
- FLUSH_CYCLES, 2, cycles `flush` is held after commit; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_1 / valid_2  in  1  lane holds a live instruction; lane 1 is older
- exc_raw_1 / exc_raw_2  in  8  raw flags: bit0 AdEL-IF, 1 RI, 2 Ov, 3 Break, 4 Syscall, 5 AdEL-MA, 6 ERET, 7 AdES
- is_delay_1 / is_delay_2  in  1  instruction sits in a branch delay slot
- pc_1 / pc_2  in  32  exception PC of the lane
- vaddr_1 / vaddr_2  in  32  data virtual address of the lane
- epc_i  in  32  EPC value from CP0
- int_contr_word_1 / int_contr_word_2  out  16  bit15 valid, bit8 delay, bits7:0 one-hot code, other bits 0
- pc_o_1 / pc_o_2  out  32  PC passed to CP0
- vaddr_o_1 / vaddr_o_2  out  32  bad address passed to CP0
- kill_2  out  1  lane 2 is squashed in the commit cycle
- flush  out  1  pipeline flush
- redirect_valid  out  1  redirect request
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts the redirect

## Operation
- FSM states: IDLE, COMMIT, FLUSH, REDIRECT.
- In IDLE, a lane is excepting when `valid` is 1 and `exc_raw != 0`. If any lane is excepting, the FSM registers the result and moves to COMMIT.
- Lane selection: lane 1 wins whenever it is excepting, and lane 2's word is then forced to 0. Lane 2 is selected only when lane 1 is not excepting.
- In-lane priority, highest first: bit0, 1, 2, 3, 4, 5, 7, 6. The winning bit becomes the one-hot code and all other bits are dropped.
- COMMIT lasts exactly 1 cycle:
  - The winning lane's word has bit15=1, bit8=is_delay, and the one-hot code.
  - pc_o and vaddr_o of the winning lane come from the registered inputs.
  - `kill_2` is 1 when lane 1 won and valid_2=1.
- On leaving COMMIT the counter is loaded with FLUSH_CYCLES and the FSM enters FLUSH. `flush`=1 throughout FLUSH, and the counter decrements each cycle. The FSM moves to REDIRECT when the counter reaches 1.
- REDIRECT:
  - `redirect_valid`=1.
  - `redirect_pc` = epc_i sampled on entry if the code was ERET (0x40), else EXC_VECTOR.
  - Both outputs hold until `redirect_ready`=1, then the FSM returns to IDLE.
- Outside IDLE all inputs are ignored; new exceptions are not queued.
- Exceptions are committed regardless of CP0's EXL; masking is CP0's job.

## Timing
- Reset values: all words 0, pc_o/vaddr_o 0, kill_2 0, flush 0, redirect_valid 0, redirect_pc 0, FSM IDLE, counter 0.
- Latency from an excepting input edge:
  - Word visible for the cycle following that edge.
  - `flush` asserted for cycles +2 .. +1+FLUSH_CYCLES.
  - `redirect_valid` first at +2+FLUSH_CYCLES.
- `redirect_valid` is never deasserted without `redirect_ready`. Zero-wait acceptance gives IDLE on the next cycle.
- Back-to-back: an exception present on the cycle IDLE is re-entered is accepted.
- Reset asserted in any state returns everything to the reset values immediately, with no pending redirect retained.
- Word outputs are registered. CP0 decodes them combinationally in the same cycle.

## Configuration
- `EXC_COMMIT_STATS_EN` defined:
  - Adds output `exc_count` (32 bits), which increments once per COMMIT and wraps from 0xFFFF_FFFF to 0.
  - Adds output `eret_count` (16 bits), which increments on ERET commits and saturates at 0xFFFF.
  - Both are reset to 0.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Structure
- Shared package `exc_pkg`: exception bit index constants, 16-bit word field positions, FSM state enum, EXC_VECTOR default.
- Sub-module `exc_prio_enc`: combinational 8-bit priority-to-one-hot encoder, instantiated once per lane.

## Test plan
- Lane 1 Ov (0x04), is_delay_1=1, pc_1=0x8000_0010 -> word_1=0x8104 for 1 cycle, pc_o_1=0x8000_0010, flush for 2 cycles, redirect_pc=0xBFC0_0380.
- Lane 1 Syscall, lane 2 RI, both valid -> word_1=0x8010, word_2=0x0000, kill_2=1.
- Lane 2 only AdES (0x80), vaddr_2=0x0000_1003 -> word_2=0x8080, vaddr_o_2=0x0000_1003.
- Lane 1 raw 0x41 (AdEL-IF plus ERET) -> code 0x01. Plain ERET with epc_i=0x8000_0200 -> redirect_pc=0x8000_0200.
- redirect_ready held low 5 cycles -> redirect_valid stays 1 with a stable pc; a new exception arriving meanwhile is ignored.
- Reset pulsed during FLUSH -> all outputs 0 that cycle, FSM in IDLE; with stats enabled, exc_count=0.
